// File: rtl/iq_pattern_player.sv
// iq_pattern_player: run-time loadable I/Q sample RAM with one-shot or
// gap-free looped replay, one sample per clock, feeding the 2-bit pin DACs.
module iq_pattern_player #(
  parameter int              ADDR_W    = 13,
  parameter int              DAC_W     = 2,
  parameter logic [DAC_W-1:0] IDLE_CODE = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [2*DAC_W-1:0] wr_data,
  input  logic               wr_last,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  output logic [DAC_W-1:0]   out_i,
  output logic [DAC_W-1:0]   out_q,
  output logic               playing,
  output logic               loaded,
  output logic [15:0]        pass_count
);

  typedef enum logic [1:0] {
    EMPTY,
    LOADING,
    READY,
    PLAYING
  } state_t;

  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     length_q, length_d;
  logic [15:0]         pass_q, pass_d;
  logic                rd_vld_q, rd_vld_d;
  logic [DAC_W-1:0]    out_i_q, out_i_d;
  logic [DAC_W-1:0]    out_q_q, out_q_d;
  logic                playing_q, playing_d;
  logic                loaded_q, loaded_d;

  logic [2*DAC_W-1:0]  mem [2**ADDR_W];
  logic [2*DAC_W-1:0]  rd_data_q;

  logic                wr_fire;
  logic [ADDR_W-1:0]   wr_addr;
  logic                last_rd;

  // The loader may write in any state except while the pattern is being played.
  assign wr_ready = (state_q != PLAYING);
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_addr  = (state_q == LOADING) ? wr_ptr_q : '0;
  assign last_rd  = ({1'b0, rd_ptr_q} == (length_q - 1'b1));

  // Next-state logic; an accepted load beat in READY takes precedence over start.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    length_d  = length_q;
    pass_d    = pass_q;
    rd_vld_d  = 1'b0;
    case (state_q)
      EMPTY, LOADING, READY: begin
        if (wr_fire) begin
          wr_ptr_d = wr_addr + 1'b1;
          if (wr_last || (wr_addr == TOP_ADDR)) begin
            state_d  = READY;
            length_d = {1'b0, wr_addr} + 1'b1;
          end else begin
            state_d = LOADING;
          end
        end else if ((state_q == READY) && start && !stop) begin
          state_d  = PLAYING;
          rd_ptr_d = '0;
          pass_d   = '0;
        end
      end
      PLAYING: begin
        if (stop) begin
          state_d = READY;
        end else begin
          rd_vld_d = 1'b1;
          if (last_rd) begin
            if (pass_q != 16'hFFFF) begin
              pass_d = pass_q + 16'd1;
            end
            if (loop_en) begin
              rd_ptr_d = '0;
            end else begin
              state_d = READY;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = EMPTY;
    endcase

    out_i_d   = rd_vld_q ? rd_data_q[DAC_W-1:0]       : IDLE_CODE;
    out_q_d   = rd_vld_q ? rd_data_q[2*DAC_W-1:DAC_W] : IDLE_CODE;
    playing_d = (state_d == PLAYING);
    loaded_d  = (state_d == READY) || (state_d == PLAYING);
  end

  // Sample RAM: write port from the loader, synchronous read at the play pointer.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_ptr_q];
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= EMPTY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      length_q  <= '0;
      pass_q    <= '0;
      rd_vld_q  <= 1'b0;
      out_i_q   <= IDLE_CODE;
      out_q_q   <= IDLE_CODE;
      playing_q <= 1'b0;
      loaded_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      length_q  <= length_d;
      pass_q    <= pass_d;
      rd_vld_q  <= rd_vld_d;
      out_i_q   <= out_i_d;
      out_q_q   <= out_q_d;
      playing_q <= playing_d;
      loaded_q  <= loaded_d;
    end
  end

  assign out_i      = out_i_q;
  assign out_q      = out_q_q;
  assign playing    = playing_q;
  assign loaded     = loaded_q;
  assign pass_count = pass_q;

endmodule
